// File: rtl/rmt_ctrl_pkg.sv
// Shared definitions for the match-action ctrl-path configurators.
// Sequencer state encoding, ctrl packet field offsets and default entry width.
// No logic; imported by the configurator blocks.
package rmt_ctrl_pkg;

    localparam int MOD_ID_OFF      = 112;
    localparam int ADDR_OFF        = 128;
    localparam int MOD_ID_BITS     = 3;
    localparam int ADDR_FIELD_BITS = 8;
    localparam int DEF_ENTRY_WIDTH = 160;

    typedef enum logic [2:0] {
        ST_WAIT_FIRST  = 3'd0,
        ST_WAIT_SECOND = 3'd1,
        ST_WAIT_THIRD  = 3'd2,
        ST_WAIT_COMMIT = 3'd3,
        ST_WRITE_PEND  = 3'd4,
        ST_FLUSH       = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/axis_byte_swap.sv
// Byte-order reversal: input byte 0 lands in the most significant output byte.
// Latency: combinational.
// Backpressure: none, pure datapath.
module axis_byte_swap #(
    parameter int BYTES = 32
) (
    input  logic [8*BYTES-1:0] data_i,
    output logic [8*BYTES-1:0] data_o
);

    for (genvar i = 0; i < BYTES; i++) begin : g_byte
        assign data_o[8*(BYTES-1-i) +: 8] = data_i[8*i +: 8];
    end

endmodule

// File: rtl/parse_act_cfg_ctrl.sv
// Parse-action table write sequencer: decodes ctrl packets into 160-bit entries; optional PARSE_CFG_STATS_EN adds counters.
// Latency: ctrl pass-through 1 cycle; RAM strobe 2 cycles after the commit beat when the parser is idle.
// Backpressure: ctrl tready drops only while a write waits for lookup_busy to clear.
module parse_act_cfg_ctrl
    import rmt_ctrl_pkg::*;
#(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         ENTRY_WIDTH          = DEF_ENTRY_WIDTH,
    parameter int         ADDR_WIDTH           = 5,
    parameter logic [2:0] PARSER_MOD_ID        = 3'b0
) (
    input  logic                              axis_clk,
    input  logic                              areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
    input  logic                              ctrl_s_axis_tvalid,
    input  logic                              ctrl_s_axis_tlast,
    output logic                              ctrl_s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
    output logic                              ctrl_m_axis_tvalid,
    output logic                              ctrl_m_axis_tlast,
    input  logic                              lookup_busy,
    output logic                              ram_wr_en,
    output logic [ADDR_WIDTH-1:0]             ram_wr_addr,
    output logic [ENTRY_WIDTH-1:0]            ram_wr_data,
`ifdef PARSE_CFG_STATS_EN
    output logic [15:0]                       cfg_wr_cnt,
    output logic [15:0]                       cfg_drop_cnt,
`endif
    output logic                              cfg_err
);

    ctrl_state_e                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic [ENTRY_WIDTH-1:0]           entry_q, entry_d;
    logic                             exit_last_q, exit_last_d;
    logic                             err_d, wr_fire;
    logic                             ram_wr_en_q, cfg_err_q;
    logic [ADDR_WIDTH-1:0]            ram_wr_addr_q;
    logic [ENTRY_WIDTH-1:0]           ram_wr_data_q;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   m_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_tkeep_q;
    logic                             m_tvalid_q, m_tlast_q;
    logic [ENTRY_WIDTH-1:0]           entry_swapped;
    logic                             accept, mod_match, addr_ok;

    // Reversing only the low ENTRY_WIDTH/8 bytes equals the top of a full-width swap.
    axis_byte_swap #(.BYTES(ENTRY_WIDTH/8)) u_swap (
        .data_i (ctrl_s_axis_tdata[ENTRY_WIDTH-1:0]),
        .data_o (entry_swapped)
    );

    assign ctrl_s_axis_tready = (state_q != ST_WRITE_PEND);
    assign accept    = ctrl_s_axis_tvalid && ctrl_s_axis_tready;
    assign mod_match = (ctrl_s_axis_tdata[MOD_ID_OFF +: MOD_ID_BITS] == PARSER_MOD_ID);
    assign addr_ok   = ((ctrl_s_axis_tdata[ADDR_OFF +: ADDR_FIELD_BITS] >> ADDR_WIDTH) == '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        entry_d     = entry_q;
        exit_last_d = exit_last_q;
        err_d       = 1'b0;
        wr_fire     = 1'b0;
        case (state_q)
            ST_WAIT_FIRST: begin
                if (accept && !ctrl_s_axis_tlast) state_d = ST_WAIT_SECOND;
            end
            ST_WAIT_SECOND: begin
                if (accept) begin
                    if (ctrl_s_axis_tlast) begin
                        state_d = ST_WAIT_FIRST;
                        err_d   = mod_match;
                    end else if (mod_match && addr_ok) begin
                        addr_d  = ctrl_s_axis_tdata[ADDR_OFF +: ADDR_WIDTH];
                        state_d = ST_WAIT_THIRD;
                    end else begin
                        err_d   = mod_match;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_WAIT_THIRD: begin
                if (accept) begin
                    if (ctrl_s_axis_tlast) begin
                        state_d = ST_WAIT_FIRST;
                        err_d   = 1'b1;
                    end else begin
                        entry_d = entry_swapped;
                        state_d = ST_WAIT_COMMIT;
                    end
                end
            end
            ST_WAIT_COMMIT: begin
                if (accept) begin
                    exit_last_d = ctrl_s_axis_tlast;
                    state_d     = ST_WRITE_PEND;
                end
            end
            ST_WRITE_PEND: begin
                // Hold the write until the parser leaves its lookup window.
                if (!lookup_busy) begin
                    wr_fire = 1'b1;
                    state_d = exit_last_q ? ST_WAIT_FIRST : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (accept && ctrl_s_axis_tlast) state_d = ST_WAIT_FIRST;
            end
            default: state_d = ST_WAIT_FIRST;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q       <= ST_WAIT_FIRST;
            addr_q        <= '0;
            entry_q       <= '0;
            exit_last_q   <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            cfg_err_q     <= 1'b0;
            m_tdata_q     <= '0;
            m_tuser_q     <= '0;
            m_tkeep_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            entry_q     <= entry_d;
            exit_last_q <= exit_last_d;
            ram_wr_en_q <= wr_fire;
            cfg_err_q   <= err_d;
            if (wr_fire) begin
                ram_wr_addr_q <= addr_q;
                ram_wr_data_q <= entry_q;
            end
            m_tvalid_q <= accept;
            if (accept) begin
                m_tdata_q <= ctrl_s_axis_tdata;
                m_tuser_q <= ctrl_s_axis_tuser;
                m_tkeep_q <= ctrl_s_axis_tkeep;
                m_tlast_q <= ctrl_s_axis_tlast;
            end
        end
    end

`ifdef PARSE_CFG_STATS_EN
    logic [15:0] wr_cnt_q, drop_cnt_q;

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (ram_wr_en_q && (wr_cnt_q != 16'hFFFF))  wr_cnt_q   <= wr_cnt_q + 16'd1;
            if (cfg_err_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign cfg_wr_cnt   = wr_cnt_q;
    assign cfg_drop_cnt = drop_cnt_q;
`endif

    assign ram_wr_en          = ram_wr_en_q;
    assign ram_wr_addr        = ram_wr_addr_q;
    assign ram_wr_data        = ram_wr_data_q;
    assign cfg_err            = cfg_err_q;
    assign ctrl_m_axis_tdata  = m_tdata_q;
    assign ctrl_m_axis_tuser  = m_tuser_q;
    assign ctrl_m_axis_tkeep  = m_tkeep_q;
    assign ctrl_m_axis_tvalid = m_tvalid_q;
    assign ctrl_m_axis_tlast  = m_tlast_q;

endmodule

// File: doc/parse_act_cfg_ctrl.md
Name: parse_act_cfg_ctrl

Overview:
- Control-path sequencer that owns the write side of the parser's parse-action table (160-bit entries indexed by VLAN-derived address).
- Decodes configuration packets on the ctrl AXI-Stream, filters them by module ID, and assembles one 160-bit entry per packet.
- Arbitrates RAM writes against the parser's lookup window, so a table entry never changes while the parser is reading it.
- Forwards every ctrl beat downstream with a 1-cycle register stage, keeping the daisy-chained ctrl path intact.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256: ctrl tdata width; only 256 is supported.
- C_S_AXIS_TUSER_WIDTH, 128: ctrl tuser width.
- ENTRY_WIDTH, 160: parse-action entry width.
- ADDR_WIDTH, 5: table address width (32 entries).
- PARSER_MOD_ID, 3'b0: module ID this instance accepts.

Ports:
- axis_clk  in  1  sole clock
- areset  in  1  reset; the block uses one clock and this reset is synchronous and active-high
- ctrl_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  ctrl stream in
- ctrl_s_axis_tready  out  1  ctrl stream ready (combinational)
- ctrl_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  registered pass-through; no downstream ready
- lookup_busy  in  1  high while the parser is reading the table (parse window)
- ram_wr_en  out  1  one-cycle write strobe
- ram_wr_addr  out  ADDR_WIDTH  write address
- ram_wr_data  out  ENTRY_WIDTH  write data
- cfg_err  out  1  one-cycle pulse when a packet addressed to this module is dropped

Behaviour:
- Reset:
  - All outputs are 0, except ctrl_s_axis_tready, which is 1 in WAIT_FIRST.
  - State becomes WAIT_FIRST.
  - Any pending write is discarded; reset mid-packet leaves no partial write.
- Beat acceptance: a beat is accepted when tvalid and tready are both high.
- Ready rule: ctrl_s_axis_tready = (state != WRITE_PEND).
- Pass-through:
  - Each accepted beat appears on ctrl_m_* exactly 1 cycle later with tvalid=1.
  - When no beat is accepted, ctrl_m_axis_tvalid=0 and the data fields hold their last value.
- Packet layout:
  - Beat 0: header only; its contents are ignored.
  - Beat 1: mod_id = tdata[112+:8], compared on bits [2:0]; addr = tdata[128+:8].
  - Beat 2: data source. Byte-swap all 32 bytes of tdata (byte 0 becomes the MSB); entry = swapped[255-:160].
  - Beat 3: commit beat.
- FSM:
  - WAIT_FIRST: on an accepted beat, go to WAIT_SECOND. If that beat has tlast, stay in WAIT_FIRST.
  - WAIT_SECOND: on an accepted beat:
    - mod_id match and addr < 2^ADDR_WIDTH: latch addr and go to WAIT_THIRD.
    - mod_id match and addr out of range: pulse cfg_err, go to FLUSH.
    - no match: go to FLUSH.
    - Beat has tlast: go to WAIT_FIRST; pulse cfg_err only if mod_id matched.
  - WAIT_THIRD: on an accepted beat, latch the entry and go to WAIT_COMMIT. If the beat has tlast, go to WAIT_FIRST and pulse cfg_err (truncated packet).
  - WAIT_COMMIT: on an accepted beat, go to WRITE_PEND. Record tlast so the exit target is WAIT_FIRST (tlast=1) or FLUSH (tlast=0).
  - WRITE_PEND:
    - tready=0.
    - On the first cycle with lookup_busy=0: at that edge register ram_wr_en=1 with the latched addr/data, then go to the recorded exit target.
    - While lookup_busy=1: remain in WRITE_PEND indefinitely; the ctrl stream stalls.
  - FLUSH: discard beats (still passed through) until an accepted beat has tlast, then go to WAIT_FIRST.
- Latency: with lookup_busy=0, a commit beat accepted in cycle c produces ram_wr_en high in cycle c+2, for exactly one cycle.
- ram_wr_addr and ram_wr_data are stable from the strobe until the next strobe.
- Back-to-back packets: the next beat 0 can be accepted in cycle c+2.

Optional Feature:
- Macro: PARSE_CFG_STATS_EN.
- Defined:
  - Adds outputs cfg_wr_cnt[15:0] and cfg_drop_cnt[15:0], both saturating at 16'hFFFF and reset to 0.
  - cfg_wr_cnt increments on each ram_wr_en.
  - cfg_drop_cnt increments on each cfg_err.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package rmt_ctrl_pkg holds:
  - FSM state encoding.
  - Ctrl packet field offsets: MOD_ID_OFF=112, ADDR_OFF=128, MOD_ID_BITS=3.
  - ENTRY_WIDTH default.
- One natural sub-module: axis_byte_swap (combinational 32-byte reversal), reusable by other stage configurators.

Test Plan:
- Basic write: 4-beat packet, mod_id=0, addr=8'h05, beat2 bytes 0..19 = 8'h01..8'h14, lookup_busy=0 -> ram_wr_en pulses once in cycle c+2, ram_wr_addr=5, ram_wr_data[159:152]=8'h01, ram_wr_data[7:0]=8'h14.
- Foreign module: mod_id=3 -> no ram_wr_en, no cfg_err; all 4 beats appear on ctrl_m_* 1 cycle delayed, tlast on beat 3.
- Arbitration stall: lookup_busy=1 for 10 cycles after the commit beat -> tready=0 for those 10 cycles; ram_wr_en in the cycle after lookup_busy falls; the next packet is accepted afterwards.
- Bad address: mod_id=0, addr=8'h40 -> cfg_err one pulse, no write, FSM back in WAIT_FIRST after tlast.
- Truncated packet: tlast on beat 2 -> cfg_err pulse, no write; the following valid packet (addr=1) writes correctly.
- Reset mid-operation: areset asserted while in WRITE_PEND with lookup_busy=1 -> no ram_wr_en ever issued; tready=1 on the cycle after reset deasserts.
